// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: one radix-2 step per cycle, HI/LO result registers.
// Signed MULT/DIV selected by OP[0] only when MDU_SIGNED_EN is defined.
module mdu_iter #(
    parameter int WL = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [1:0]    OP,
    input  logic [WL-1:0] SrcA,
    input  logic [WL-1:0] SrcB,
    input  logic          HILO_WE,
    input  logic          HILO_SEL,
    input  logic [WL-1:0] HILO_Din,
    output logic          BUSY,
    output logic          DONE,
    output logic [WL-1:0] HI,
    output logic [WL-1:0] LO
);

    localparam int CW = $clog2(WL);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        FIN
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic          is_div_q;
    logic [WL:0]   acc_hi_q;
    logic [WL-1:0] acc_lo_q;
    logic [WL-1:0] b_q;
    logic [WL-1:0] hi_q;
    logic [WL-1:0] lo_q;

    logic          accept;
    logic          last;
    logic [WL-1:0] a_mag;
    logic [WL-1:0] b_mag;
    logic [WL:0]   sum;
    logic [WL:0]   shifted;
    logic [WL:0]   diff;
    logic [WL:0]   hi_n;
    logic [WL-1:0] lo_n;
    logic [2*WL-1:0] prod;
    logic [WL-1:0] res_hi;
    logic [WL-1:0] res_lo;

    assign accept = START && (state_q == IDLE || state_q == FIN);
    assign last   = (cnt_q == CW'(WL - 1));
    assign BUSY   = (state_q == CALC) || (state_q == FIX);
    assign DONE   = (state_q == FIN);
    assign HI     = hi_q;
    assign LO     = lo_q;

`ifdef MDU_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg_q_q;
    logic neg_r_q;

    assign a_neg = OP[0] & SrcA[WL-1];
    assign b_neg = OP[0] & SrcB[WL-1];
    assign a_mag = a_neg ? -SrcA : SrcA;
    assign b_mag = b_neg ? -SrcB : SrcB;
`else
    logic op_unused;

    assign op_unused = OP[0];
    assign a_mag     = SrcA;
    assign b_mag     = SrcB;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (START) state_d = CALC;
            CALC: if (last) state_d = FIX;
            FIX:  state_d = FIN;
            FIN:  state_d = START ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
    // divide shifts the dividend out of acc_lo and the quotient bits in at the bottom.
    always_comb begin
        sum     = acc_lo_q[0] ? acc_hi_q + {1'b0, b_q} : acc_hi_q;
        shifted = {acc_hi_q[WL-1:0], acc_lo_q[WL-1]};
        diff    = shifted - {1'b0, b_q};
        hi_n    = {1'b0, sum[WL:1]};
        lo_n    = {sum[0], acc_lo_q[WL-1:1]};
        if (is_div_q) begin
            if (!diff[WL]) begin
                hi_n = diff;
                lo_n = {acc_lo_q[WL-2:0], 1'b1};
            end else begin
                hi_n = shifted;
                lo_n = {acc_lo_q[WL-2:0], 1'b0};
            end
        end
    end

    assign prod = {acc_hi_q[WL-1:0], acc_lo_q};

    always_comb begin
        {res_hi, res_lo} = prod;
`ifdef MDU_SIGNED_EN
        if (!is_div_q) begin
            {res_hi, res_lo} = neg_q_q ? -prod : prod;
        end else begin
            res_lo = neg_q_q ? -acc_lo_q : acc_lo_q;
            res_hi = neg_r_q ? -acc_hi_q[WL-1:0] : acc_hi_q[WL-1:0];
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MDU_SIGNED_EN
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_div_q <= OP[1];
                acc_hi_q <= '0;
                acc_lo_q <= a_mag;
                b_q      <= b_mag;
                cnt_q    <= '0;
`ifdef MDU_SIGNED_EN
                neg_q_q  <= a_neg ^ b_neg;
                neg_r_q  <= a_neg;
`endif
            end else if (state_q == CALC) begin
                acc_hi_q <= hi_n;
                acc_lo_q <= lo_n;
                cnt_q    <= cnt_q + CW'(1);
            end
            if (state_q == FIX) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
            // Direct writes only land when idle or in FIN, so they follow the result write.
            if (HILO_WE && !BUSY) begin
                if (HILO_SEL) hi_q <= HILO_Din;
                else          lo_q <= HILO_Din;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter with an arithmetic reference model and per-cycle compare.
// Honours MDU_SIGNED_EN the same way as the design.
module tb_mdu_iter;

    localparam int WL = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic [1:0]    OP;
    logic [WL-1:0] SrcA;
    logic [WL-1:0] SrcB;
    logic          HILO_WE;
    logic          HILO_SEL;
    logic [WL-1:0] HILO_Din;
    logic          BUSY;
    logic          DONE;
    logic [WL-1:0] HI;
    logic [WL-1:0] LO;

    int errs   = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    mdu_iter #(.WL(WL)) dut (
        .CLK(CLK),
        .RST(RST),
        .START(START),
        .OP(OP),
        .SrcA(SrcA),
        .SrcB(SrcB),
        .HILO_WE(HILO_WE),
        .HILO_SEL(HILO_SEL),
        .HILO_Din(HILO_Din),
        .BUSY(BUSY),
        .DONE(DONE),
        .HI(HI),
        .LO(LO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        bit     sg;
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [31:0] qq;
`ifdef MDU_SIGNED_EN
        sg = op[0];
`else
        sg = 1'b0;
`endif
        sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
        if (!op[1]) return 64'(sa * sb);
        if (b == 0) begin
            qq = (sg && a[31]) ? 32'h1 : 32'hFFFFFFFF;
            return {a, qq};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    int          m_cnt  = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [31:0] p_hi   = '0;
    logic [31:0] p_lo   = '0;

    always @(posedge CLK) begin
        if (RST) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1'b1;
                end
            end else begin
                if (START) begin
                    {p_hi, p_lo} = ref_op(OP, SrcA, SrcB);
                    m_cnt = WL + 1;
                end
                if (HILO_WE) begin
                    if (HILO_SEL) m_hi = HILO_Din;
                    else          m_lo = HILO_Din;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("busy", 64'(BUSY), 64'(m_cnt > 0));
            check("done", 64'(DONE), 64'(m_done));
            check("hi", 64'(HI), 64'(m_hi));
            check("lo", 64'(LO), 64'(m_lo));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat, output int bsy);
        START = 1'b1;
        OP    = op;
        SrcA  = a;
        SrcB  = b;
        tick();
        START = 1'b0;
        lat   = 1;
        bsy   = 0;
        while (!DONE && lat < 100) begin
            if (BUSY) bsy++;
            tick();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int lat;
        int bsy;
        int seen;
        RST      = 1'b1;
        START    = 1'b0;
        OP       = 2'b00;
        SrcA     = '0;
        SrcB     = '0;
        HILO_WE  = 1'b0;
        HILO_SEL = 1'b0;
        HILO_Din = '0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        RST = 1'b0;
        tick();

        run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bsy);
        check("multu_lat", 64'(lat), 64'd34);
        check("multu_busy", 64'(bsy), 64'd33);
        check("multu", {HI, LO}, 64'hFFFFFFFE_00000001);
        tick();

        run(2'b01, 32'hFFFFFFFD, 32'h00000005, lat, bsy);
`ifdef MDU_SIGNED_EN
        check("mult", {HI, LO}, 64'hFFFFFFFF_FFFFFFF1);
`else
        check("mult", {HI, LO}, 64'h00000004_FFFFFFF1);
`endif
        run(2'b11, 32'hFFFFFFF9, 32'h00000002, lat, bsy);
        check("div_fin_lat", 64'(lat), 64'd34);
`ifdef MDU_SIGNED_EN
        check("div_neg", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
`else
        check("div_neg", {HI, LO}, 64'h00000001_7FFFFFFC);
`endif
        tick();

        run(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, bsy);
`ifdef MDU_SIGNED_EN
        check("div_ovf", {HI, LO}, 64'h00000000_80000000);
`else
        check("div_ovf", {HI, LO}, 64'h80000000_00000000);
`endif
        tick();

        run(2'b10, 32'h00000064, 32'h0, lat, bsy);
        check("divu0_lat", 64'(lat), 64'd34);
        check("divu0", {HI, LO}, 64'h00000064_FFFFFFFF);
        HILO_WE  = 1'b1;
        HILO_SEL = 1'b0;
        HILO_Din = 32'h00001234;
        tick();
        HILO_WE = 1'b0;
        check("fin_write", {HI, LO}, 64'h00000064_00001234);

        run(2'b10, 32'd1000, 32'd7, lat, bsy);
        check("divu", {HI, LO}, {32'd6, 32'd142});
        tick();

        START = 1'b1;
        OP    = 2'b00;
        SrcA  = 32'd3;
        SrcB  = 32'd4;
        tick();
        START = 1'b0;
        repeat (3) tick();
        START    = 1'b1;
        OP       = 2'b10;
        SrcA     = 32'd9;
        SrcB     = 32'd3;
        HILO_WE  = 1'b1;
        HILO_SEL = 1'b0;
        HILO_Din = 32'hDEADBEEF;
        tick();
        START   = 1'b0;
        HILO_WE = 1'b0;
        seen = 0;
        while (!DONE && seen < 100) begin
            tick();
            seen++;
        end
        check("ignore_busy", {HI, LO}, 64'h00000000_0000000C);
        tick();
        check("fin_to_idle", 64'(BUSY), 64'd0);

        START    = 1'b1;
        OP       = 2'b00;
        SrcA     = 32'd2;
        SrcB     = 32'd3;
        HILO_WE  = 1'b1;
        HILO_SEL = 1'b1;
        HILO_Din = 32'h11111111;
        tick();
        START   = 1'b0;
        HILO_WE = 1'b0;
        check("we_with_start", 64'(HI), 64'h11111111);
        seen = 0;
        while (!DONE && seen < 100) begin
            tick();
            seen++;
        end
        check("start_overwrite", {HI, LO}, 64'h00000000_00000006);
        tick();

        START = 1'b1;
        OP    = 2'b00;
        SrcA  = 32'd5;
        SrcB  = 32'd6;
        tick();
        START = 1'b0;
        repeat (9) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort_busy", 64'(BUSY), 64'd0);
        check("abort_hilo", {HI, LO}, 64'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (DONE) seen++;
        end
        check("abort_nodone", 64'(seen), 64'd0);
        HILO_WE  = 1'b1;
        HILO_SEL = 1'b1;
        HILO_Din = 32'hA5A5A5A5;
        tick();
        HILO_WE = 1'b0;
        check("mthi", {HI, LO}, 64'hA5A5A5A5_00000000);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
